// File: rtl/interrupt_ctrl16_if.sv
// interrupt_ctrl16 bus: request lines, mask write port,
// CPU handshake and debug view of the pending register.
interface interrupt_ctrl16_if;
   logic [15:0] IRQ;
   logic        MASK_WE;
   logic [15:0] MASK_IN;
   logic        INT_ACK;
   logic        INT_DONE;
   logic        INT_REQ;
   logic [3:0]  S;
   logic        IN_SERVICE;
   logic [15:0] PENDING;

   modport master (
      output IRQ, MASK_WE, MASK_IN, INT_ACK, INT_DONE,
      input  INT_REQ, S, IN_SERVICE, PENDING
   );

   modport slave (
      input  IRQ, MASK_WE, MASK_IN, INT_ACK, INT_DONE,
      output INT_REQ, S, IN_SERVICE, PENDING
   );
endinterface

// File: rtl/interrupt_ctrl16.sv
// 16-source edge-captured, fixed-priority interrupt controller
// driving the select of a downstream 16:1 vector mux.
module interrupt_ctrl16 (
   input logic              CLK,
   input logic              RST_N,
   interrupt_ctrl16_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [3:0]  sel;
   logic [3:0]  sel_n;
   logic [15:0] pending;
   logic [15:0] pending_n;
   logic [15:0] mask;
   logic [15:0] irq_d;
   logic [15:0] cand;
   logic [15:0] clr;
   logic [3:0]  win;
   logic        any;
   logic        take;

   assign cand = pending & mask;
   assign any  = |cand;

   // lowest set candidate index wins
   always_comb begin
      win = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (cand[i]) win = 4'(i);
      end
   end

   // next state, select and acknowledge decode
   always_comb begin
      state_n = state;
      sel_n   = sel;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               sel_n   = win;
               state_n = REQ;
            end
         end
         REQ: begin
            if (bus.INT_ACK) begin
               take    = 1'b1;
               state_n = SERVICE;
            end
         end
         SERVICE: begin
            if (bus.INT_DONE) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // ack clears the granted bit; a fresh edge in the same cycle wins
   always_comb begin
      clr       = take ? (16'd1 << sel) : 16'd0;
      pending_n = (pending & ~clr) | (bus.IRQ & ~irq_d);
   end

   // FSM and select registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         sel   <= 4'd0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
      end
   end

   // edge history, pending and mask registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         irq_d   <= 16'd0;
         pending <= 16'd0;
         mask    <= 16'd0;
      end else begin
         irq_d   <= bus.IRQ;
         pending <= pending_n;
         if (bus.MASK_WE) mask <= bus.MASK_IN;
      end
   end

   assign bus.INT_REQ    = (state == REQ);
   assign bus.IN_SERVICE = (state == SERVICE);
   assign bus.S          = sel;
   assign bus.PENDING    = pending;

endmodule

// File: tb/tb_interrupt_ctrl16.sv
// Directed self-checking bench for interrupt_ctrl16:
// reset, mask gating, priority, handshake, set/clear races.
module tb_interrupt_ctrl16;

   logic CLK;
   logic RST_N;
   int   total;
   int   bad;

   interrupt_ctrl16_if bus ();

   interrupt_ctrl16 dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_ack();
      bus.INT_ACK = 1'b1;
      tick();
      bus.INT_ACK = 1'b0;
   endtask

   task automatic pulse_done();
      bus.INT_DONE = 1'b1;
      tick();
      bus.INT_DONE = 1'b0;
   endtask

   task automatic test_reset();
      RST_N        = 1'b0;
      bus.IRQ      = 16'h0;
      bus.MASK_WE  = 1'b0;
      bus.MASK_IN  = 16'h0;
      bus.INT_ACK  = 1'b0;
      bus.INT_DONE = 1'b0;
      #23;
      total++;
      if ({bus.INT_REQ, bus.IN_SERVICE, bus.S, bus.PENDING} !== 22'h0) begin
         bad++;
         $display("FAIL rst_hold got req=%b svc=%b s=%0d pend=%h exp all 0",
                  bus.INT_REQ, bus.IN_SERVICE, bus.S, bus.PENDING);
      end
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      tick();
      total++;
      if ({bus.INT_REQ, bus.IN_SERVICE, bus.S, bus.PENDING} !== 22'h0) begin
         bad++;
         $display("FAIL rst_rel got req=%b svc=%b s=%0d pend=%h exp all 0",
                  bus.INT_REQ, bus.IN_SERVICE, bus.S, bus.PENDING);
      end
   endtask

   task automatic test_mask_gate();
      bus.IRQ = 16'h0008;
      tick();
      bus.IRQ = 16'h0;
      tick();
      total++;
      if (bus.PENDING !== 16'h0008 || bus.INT_REQ !== 1'b0) begin
         bad++;
         $display("FAIL masked got pend=%h req=%b exp 0008 0",
                  bus.PENDING, bus.INT_REQ);
      end
      bus.MASK_WE = 1'b1;
      bus.MASK_IN = 16'hFFFF;
      tick();
      bus.MASK_WE = 1'b0;
      total++;
      if (bus.INT_REQ !== 1'b0) begin
         bad++;
         $display("FAIL mask_old got req=%b exp 0", bus.INT_REQ);
      end
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd3) begin
         bad++;
         $display("FAIL mask_new got req=%b s=%0d exp 1 3",
                  bus.INT_REQ, bus.S);
      end
      pulse_ack();
      total++;
      if (bus.IN_SERVICE !== 1'b1 || bus.INT_REQ !== 1'b0 ||
          bus.PENDING !== 16'h0) begin
         bad++;
         $display("FAIL ack3 got svc=%b req=%b pend=%h exp 1 0 0000",
                  bus.IN_SERVICE, bus.INT_REQ, bus.PENDING);
      end
      pulse_done();
      total++;
      if (bus.IN_SERVICE !== 1'b0 || bus.INT_REQ !== 1'b0) begin
         bad++;
         $display("FAIL done3 got svc=%b req=%b exp 0 0",
                  bus.IN_SERVICE, bus.INT_REQ);
      end
   endtask

   task automatic test_priority();
      bus.IRQ = 16'h0204;
      tick();
      bus.IRQ = 16'h0;
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd2 ||
          bus.PENDING !== 16'h0204) begin
         bad++;
         $display("FAIL prio_first got req=%b s=%0d pend=%h exp 1 2 0204",
                  bus.INT_REQ, bus.S, bus.PENDING);
      end
      pulse_ack();
      pulse_done();
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd9) begin
         bad++;
         $display("FAIL prio_second got req=%b s=%0d exp 1 9",
                  bus.INT_REQ, bus.S);
      end
      pulse_ack();
      pulse_done();
      tick();
      total++;
      if (bus.INT_REQ !== 1'b0 || bus.PENDING !== 16'h0) begin
         bad++;
         $display("FAIL prio_empty got req=%b pend=%h exp 0 0000",
                  bus.INT_REQ, bus.PENDING);
      end
   endtask

   task automatic test_handshake();
      bus.IRQ = 16'h8000;
      tick();
      total++;
      if (bus.INT_REQ !== 1'b0 || bus.PENDING !== 16'h8000) begin
         bad++;
         $display("FAIL hs_t0 got req=%b pend=%h exp 0 8000",
                  bus.INT_REQ, bus.PENDING);
      end
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd15) begin
         bad++;
         $display("FAIL hs_t1 got req=%b s=%0d exp 1 15",
                  bus.INT_REQ, bus.S);
      end
      pulse_done();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.IN_SERVICE !== 1'b0 ||
          bus.S !== 4'd15) begin
         bad++;
         $display("FAIL stray_done got req=%b svc=%b s=%0d exp 1 0 15",
                  bus.INT_REQ, bus.IN_SERVICE, bus.S);
      end
      tick();
      tick();
      pulse_ack();
      total++;
      if (bus.IN_SERVICE !== 1'b1 || bus.INT_REQ !== 1'b0 ||
          bus.S !== 4'd15 || bus.PENDING !== 16'h0) begin
         bad++;
         $display("FAIL hs_t5 got svc=%b req=%b s=%0d pend=%h exp 1 0 15 0000",
                  bus.IN_SERVICE, bus.INT_REQ, bus.S, bus.PENDING);
      end
      pulse_ack();
      total++;
      if (bus.IN_SERVICE !== 1'b1 || bus.S !== 4'd15) begin
         bad++;
         $display("FAIL stray_ack got svc=%b s=%0d exp 1 15",
                  bus.IN_SERVICE, bus.S);
      end
      tick();
      tick();
      pulse_done();
      total++;
      if (bus.IN_SERVICE !== 1'b0 || bus.INT_REQ !== 1'b0 ||
          bus.S !== 4'd15) begin
         bad++;
         $display("FAIL hs_t9 got svc=%b req=%b s=%0d exp 0 0 15",
                  bus.IN_SERVICE, bus.INT_REQ, bus.S);
      end
      bus.IRQ = 16'h0;
      tick();
   endtask

   task automatic test_set_clear();
      bus.IRQ = 16'h0010;
      tick();
      bus.IRQ = 16'h0;
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd4) begin
         bad++;
         $display("FAIL sc_req got req=%b s=%0d exp 1 4",
                  bus.INT_REQ, bus.S);
      end
      bus.IRQ = 16'h0010;
      pulse_ack();
      bus.IRQ = 16'h0;
      total++;
      if (bus.IN_SERVICE !== 1'b1 || bus.PENDING !== 16'h0010) begin
         bad++;
         $display("FAIL sc_keep got svc=%b pend=%h exp 1 0010",
                  bus.IN_SERVICE, bus.PENDING);
      end
      pulse_done();
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd4) begin
         bad++;
         $display("FAIL sc_again got req=%b s=%0d exp 1 4",
                  bus.INT_REQ, bus.S);
      end
      pulse_ack();
      pulse_done();
   endtask

   task automatic test_mask_in_req();
      bus.IRQ = 16'h0140;
      tick();
      bus.IRQ = 16'h0;
      tick();
      bus.MASK_WE = 1'b1;
      bus.MASK_IN = 16'h0000;
      tick();
      bus.MASK_WE = 1'b0;
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd6) begin
         bad++;
         $display("FAIL mreq_hold got req=%b s=%0d exp 1 6",
                  bus.INT_REQ, bus.S);
      end
      pulse_ack();
      total++;
      if (bus.IN_SERVICE !== 1'b1 || bus.PENDING !== 16'h0100) begin
         bad++;
         $display("FAIL mreq_ack got svc=%b pend=%h exp 1 0100",
                  bus.IN_SERVICE, bus.PENDING);
      end
      pulse_done();
      tick();
      tick();
      total++;
      if (bus.INT_REQ !== 1'b0 || bus.PENDING !== 16'h0100) begin
         bad++;
         $display("FAIL mreq_none got req=%b pend=%h exp 0 0100",
                  bus.INT_REQ, bus.PENDING);
      end
   endtask

   task automatic test_reset_mid();
      bus.MASK_WE = 1'b1;
      bus.MASK_IN = 16'hFFFF;
      tick();
      bus.MASK_WE = 1'b0;
      tick();
      total++;
      if (bus.INT_REQ !== 1'b1 || bus.S !== 4'd8) begin
         bad++;
         $display("FAIL mid_req got req=%b s=%0d exp 1 8",
                  bus.INT_REQ, bus.S);
      end
      pulse_ack();
      bus.IRQ = 16'h0101;
      tick();
      bus.IRQ = 16'h0;
      total++;
      if (bus.IN_SERVICE !== 1'b1 || bus.PENDING !== 16'h0101) begin
         bad++;
         $display("FAIL mid_pre got svc=%b pend=%h exp 1 0101",
                  bus.IN_SERVICE, bus.PENDING);
      end
      #2;
      RST_N = 1'b0;
      #1;
      total++;
      if ({bus.INT_REQ, bus.IN_SERVICE, bus.S, bus.PENDING} !== 22'h0) begin
         bad++;
         $display("FAIL mid_rst got req=%b svc=%b s=%0d pend=%h exp all 0",
                  bus.INT_REQ, bus.IN_SERVICE, bus.S, bus.PENDING);
      end
      tick();
      RST_N = 1'b1;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_mask_gate();
      test_priority();
      test_handshake();
      test_set_clear();
      test_mask_in_req();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_ctrl16.md
# interrupt_ctrl16

Sixteen-source interrupt controller that detects request edges, holds them pending, arbitrates by fixed priority and drives the 4-bit select `S` of the 16-input, 16-bit vector multiplexer that sits directly downstream. The multiplexer then outputs the selected handler address to the CPU. The block runs a request/acknowledge/return handshake with the CPU control unit and allows only one interrupt in service at a time (no nesting).

## Interface
Parameters:
- None. The source count (16) and select width (4) are fixed to match the downstream vector mux.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST_N` in 1: reset; asynchronous, active-low.
- `IRQ` in 16: request lines. Bit n maps to mux input n (0→A, 1→B … 15→P). Lines are rising-edge sensitive.
- `MASK_WE` in 1: write strobe for the mask register.
- `MASK_IN` in 16: new mask value; 1 = source enabled.
- `INT_ACK` in 1: single-cycle pulse from the CPU when it takes the vector.
- `INT_DONE` in 1: single-cycle pulse from the CPU when it executes return-from-interrupt.
- `INT_REQ` out 1: interrupt request to the CPU.
- `S` out 4: vector-mux select; the index of the granted source.
- `IN_SERVICE` out 1: high while a handler is executing.
- `PENDING` out 16: pending register, exposed for debug.

## Operation
- **Edge capture.** Register `irq_d` samples `IRQ` every cycle. A bit with `IRQ[n]=1` and `irq_d[n]=0` sets `pending[n]`. Capture runs in every state.
- **Mask.** The 16-bit register loads `MASK_IN` when `MASK_WE=1`. Masking never clears pending bits; it only excludes them from arbitration.
- **Arbitration.** Combinational over the registered values `pending & mask`. The lowest set index wins, so 0 has the highest priority.
- **FSM states:** IDLE, REQ, SERVICE.
  - **IDLE:** if any candidate exists, register `S` ← winner and go to REQ. Otherwise stay in IDLE.
  - **REQ:** `INT_REQ=1` and `S` is frozen. This holds even if the source is masked meanwhile; a request is never withdrawn. On `INT_ACK`, clear `pending[S]` and go to SERVICE.
  - **SERVICE:** `IN_SERVICE=1`. On `INT_DONE`, go to IDLE.
- **Ignored inputs.** `INT_ACK` outside REQ and `INT_DONE` outside SERVICE are ignored.
- **Output decode.** `INT_REQ = (state==REQ)` and `IN_SERVICE = (state==SERVICE)`, both decoded from registered state. `S` holds its last value in IDLE and SERVICE.
- **Simultaneous events:**
  - A new edge on bit S in the same cycle as `INT_ACK` clears it: set wins, and the bit stays pending.
  - `MASK_WE` in the same cycle as an IDLE arbitration: the arbitration uses the old mask; the new mask applies from the next cycle.
  - Multiple edges arriving together all become pending and are served in priority order, one per handshake.
- **Reset (async, `RST_N=0`).** The following are cleared immediately:
  - state → IDLE
  - `S=0`, `INT_REQ=0`, `IN_SERVICE=0`
  - `pending=0`, `mask=0` (all sources disabled)
  - `irq_d=0`

  A line held high across reset release is therefore captured as an edge on the first clock. Reset in the middle of a handshake abandons it with no residue.

## Timing
- `IRQ[n]` rises before edge t0: `pending[n]` is set at t0 and visible after t0.
- If enabled and the FSM is in IDLE: `S` and `INT_REQ` are valid after t1. Latency is 2 edges from `IRQ` to `INT_REQ`.
- `INT_ACK` sampled at edge t: after t, `INT_REQ=0`, `IN_SERVICE=1` and the pending bit is cleared.
- `INT_DONE` sampled at edge t: IDLE after t. The next `INT_REQ` can appear after t+1 at the earliest.
- `S` is stable from the edge that raises `INT_REQ` through the end of SERVICE, so the vector mux output is stable for the whole handshake.
- `PENDING` is the register value, with no combinational path from `IRQ`.

## Test plan
- **Reset and mask gating.** Assert `RST_N=0`, then release. Check all outputs are 0. Pulse `IRQ[3]` with mask 0 → `PENDING=16'h0008`, `INT_REQ` stays 0. Write mask `16'hFFFF` → `INT_REQ=1`, `S=3` two cycles later.
- **Priority.** With mask `16'hFFFF`, raise `IRQ[9]` and `IRQ[2]` in the same cycle → `S=2`. `INT_ACK` then `INT_DONE` → next request has `S=9`. After its ACK/DONE, `PENDING=0` and there is no further request.
- **Handshake timing.** Raise `IRQ[15]` at t0 → `INT_REQ` after t1. `INT_ACK` at t5 → `IN_SERVICE=1`, `INT_REQ=0`. `INT_DONE` at t9 → IDLE. Check `S=15` throughout. Stray `INT_DONE` in REQ and stray `INT_ACK` in SERVICE cause no change.
- **Simultaneous set/clear.** In REQ with `S=4`, drive `INT_ACK` together with a fresh `IRQ[4]` rising edge → `pending[4]` remains 1. After `INT_DONE`, `INT_REQ` reasserts with `S=4`.
- **Mask during REQ.** In REQ with `S=6`, write mask `16'h0000` → `INT_REQ` and `S=6` are held until ACK. After DONE, no new request despite pending bits.
- **Reset mid-service.** Assert `RST_N` low asynchronously while in SERVICE with `PENDING=16'h0101` → outputs and pending are 0 immediately, without waiting for a clock edge.
